// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the two instruction-memory requesters,
// the external memory port and mem_port_arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH     = 16,
  parameter int MEM_DATA_WIDTH = 40
);
  logic                      i_halt;
  logic [ADDR_WIDTH-1:0]     i_req0_addr;
  logic [ADDR_WIDTH-1:0]     i_req1_addr;
  logic                      i_req0_valid;
  logic                      i_req1_valid;
  logic                      o_req0_ready;
  logic                      o_req1_ready;
  logic [ADDR_WIDTH-1:0]     o_mem_req_addr;
  logic                      o_mem_req_valid;
  logic [MEM_DATA_WIDTH-1:0] i_mem_data;
  logic                      i_mem_data_valid;
  logic                      o_mem_ready;
  logic [MEM_DATA_WIDTH-1:0] o_rsp_data;
  logic                      o_rsp0_valid;
  logic                      o_rsp1_valid;
  logic                      o_rsp_last;
  logic                      o_busy;
  logic                      o_owner;
  logic                      o_spurious_beat;

  // Arbiter side.
  modport slave (
    input  i_halt, i_req0_addr, i_req1_addr, i_req0_valid, i_req1_valid,
           i_mem_data, i_mem_data_valid,
    output o_req0_ready, o_req1_ready, o_mem_req_addr, o_mem_req_valid,
           o_mem_ready, o_rsp_data, o_rsp0_valid, o_rsp1_valid, o_rsp_last,
           o_busy, o_owner, o_spurious_beat
  );

  // Requester / memory side.
  modport master (
    output i_halt, i_req0_addr, i_req1_addr, i_req0_valid, i_req1_valid,
           i_mem_data, i_mem_data_valid,
    input  o_req0_ready, o_req1_ready, o_mem_req_addr, o_mem_req_valid,
           o_mem_ready, o_rsp_data, o_rsp0_valid, o_rsp1_valid, o_rsp_last,
           o_busy, o_owner, o_spurious_beat
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the shared instruction-memory port: grants, issues the
// block request, then steers NUM_BEATS returning beats to the owner.
// ARB_ROUND_ROBIN_EN selects round-robin tie-breaking; default is fixed priority (req0).
module mem_port_arbiter #(
  parameter int ADDR_WIDTH     = 16,
  parameter int MEM_DATA_WIDTH = 40,
  parameter int NUM_BEATS      = 8
) (
  input  logic               clk,
  input  logic               arst_n,
  mem_port_arbiter_if.slave  bus
);
  localparam int NUM_LANES = 2;
  localparam int CW = $clog2(NUM_BEATS) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NUM_BEATS);

  typedef enum logic [1:0] {IDLE, WAIT, RECV} state_t;

  state_t  state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic    owner, owner_nxt;
  logic    en, win, grant, beat, last;

  logic [NUM_LANES-1:0]                 req_vld;
  logic [NUM_LANES-1:0][ADDR_WIDTH-1:0] req_addr;
  logic [NUM_LANES-1:0]                 req_rdy;
  logic [NUM_LANES-1:0]                 rsp_vld;

  assign req_vld  = {bus.i_req1_valid, bus.i_req0_valid};
  assign req_addr = {bus.i_req1_addr, bus.i_req0_addr};

  // Outputs stay quiet while reset is held, not only after the next edge.
  assign en    = arst_n & ~bus.i_halt;
  assign grant = en & (state == IDLE) & (|req_vld);
  assign beat  = en & (state != IDLE) & bus.i_mem_data_valid;
  assign last  = beat & ((cnt + CW'(1)) == LAST_CNT);

`ifdef ARB_ROUND_ROBIN_EN
  // ptr names the requester that wins the next tie.
  logic ptr;
  assign win = (&req_vld) ? ptr : (req_vld[1] & ~req_vld[0]);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)    ptr <= 1'b0;
    else if (grant) ptr <= ~win;
  end
`else
  assign win = ~req_vld[0];
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    owner_nxt = owner;
    case (state)
      IDLE: if (grant) begin
        state_nxt = WAIT;
        owner_nxt = win;
      end
      WAIT, RECV: if (beat) begin
        state_nxt = last ? IDLE : RECV;
        cnt_nxt   = last ? '0 : cnt + CW'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= IDLE;
      cnt   <= '0;
      owner <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      owner <= owner_nxt;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign req_rdy[g] = grant & (win == 1'(g));
    assign rsp_vld[g] = beat & (owner == 1'(g));
  end

  assign bus.o_req0_ready    = req_rdy[0];
  assign bus.o_req1_ready    = req_rdy[1];
  assign bus.o_mem_req_valid = grant;
  assign bus.o_mem_req_addr  = grant ? req_addr[win] : '0;
  assign bus.o_mem_ready     = en & (state != IDLE);
  assign bus.o_rsp_data      = bus.i_mem_data;
  assign bus.o_rsp0_valid    = rsp_vld[0];
  assign bus.o_rsp1_valid    = rsp_vld[1];
  assign bus.o_rsp_last      = last;
  assign bus.o_busy          = (state != IDLE);
  assign bus.o_owner         = owner;
  assign bus.o_spurious_beat = en & (state == IDLE) & bus.i_mem_data_valid;
endmodule
